// File: rtl/divider_unit.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring division over 32 cycles,
// with single-cycle handling of divide-by-zero and signed overflow.
module divider_unit (
    input  logic        clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [1:0]  divsel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q;
    logic [31:0] divisor;
    logic [31:0] rem;
    logic [4:0]  count;

    // Request decode, evaluated on the live operands in IDLE/DONE.
    logic        is_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div_by_zero;
    logic        sgn_overflow;
    logic        fast_path;
    logic [31:0] fast_res;
    logic        accept;

    assign is_signed    = ~divsel[0];
    assign a_abs        = (is_signed && a[31]) ? -a : a;
    assign b_abs        = (is_signed && b[31]) ? -b : b;
    assign div_by_zero  = (b == 32'd0);
    assign sgn_overflow = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign fast_path    = div_by_zero || sgn_overflow;
    assign fast_res     = divsel[1] ? (div_by_zero ? a : 32'd0)
                                    : (div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    assign accept       = ((state == IDLE) || (state == DONE)) && start && !flush;

    // One restoring step; the 33-bit partial remainder keeps the compare exact.
    logic [32:0] rem_t;
    logic        ge;
    logic [31:0] rem_next;
    logic [31:0] q_next;

    assign rem_t    = {rem, q[31]};
    assign ge       = (rem_t >= {1'b0, divisor});
    assign rem_next = ge ? 32'(rem_t - {1'b0, divisor}) : rem_t[31:0];
    assign q_next   = {q[30:0], ge};

    // Sign fix-up applied to the values produced by the final iteration.
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;
    logic [31:0] fin_res;

    assign quot_fin = neg_q ? -q_next : q_next;
    assign rem_fin  = neg_r ? -rem_next : rem_next;
    assign fin_res  = is_rem ? rem_fin : quot_fin;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking would chain the iteration within one edge.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            res     <= 32'd0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            q       <= 32'd0;
            divisor <= 32'd0;
            rem     <= 32'd0;
            count   <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        is_rem  <= divsel[1];
                        neg_q   <= is_signed & (a[31] ^ b[31]);
                        neg_r   <= is_signed & a[31];
                        q       <= a_abs;
                        divisor <= b_abs;
                        rem     <= 32'd0;
                        count   <= 5'd31;
                        if (fast_path) begin
                            res   <= fast_res;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem   <= rem_next;
                        q     <= q_next;
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            res   <= fin_res;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: hand-computed quotients/remainders, latency,
// busy length, start-ignore, flush, async reset and back-to-back issue.
module tb_divider_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int POKE_NONE  = 0;
    localparam int POKE_START = 1;
    localparam int POKE_FLUSH = 2;
    localparam int POKE_RESET = 3;

    logic        clk;
    logic        Rst;
    logic        start;
    logic [1:0]  divsel;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_checks = 0;
    int n_errors = 0;

    divider_unit dut (
        .clk    (clk),
        .Rst    (Rst),
        .start  (start),
        .divsel (divsel),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .res    (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call just after a negedge; the request is sampled at the following posedge (E0),
    // after which the operand inputs are scrambled to show they are not used again.
    task automatic issue(input logic [1:0] sel, input logic [31:0] av, input logic [31:0] bv);
        start  = 1'b1;
        divsel = sel;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        start  = 1'b0;
        divsel = ~sel;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0000_0000;
    endtask

    // Sample on negedges after E0. exp_lat==0 means no done pulse may appear.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat,
                             input int exp_busy, input int poke_cyc, input int poke_kind);
        int lat = 0;
        int busy_cnt = 0;
        int overlap = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done && lat == 0) lat = cyc;
            if (lat != 0) break;
            if (cyc == poke_cyc) begin
                case (poke_kind)
                    POKE_START: begin
                        start  = 1'b1;
                        divsel = OP_DIVU;
                        a      = 32'd50;
                        b      = 32'd5;
                    end
                    POKE_FLUSH: flush = 1'b1;
                    POKE_RESET: begin
                        Rst = 1'b1;
                        #1;
                        check({tag, " rst busy"}, {31'd0, busy}, 32'd0);
                        check({tag, " rst done"}, {31'd0, done}, 32'd0);
                        check({tag, " rst res"}, res, 32'd0);
                        #1;
                        Rst = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " busy&done"}, 32'(overlap), 32'd0);
        check({tag, " res"}, res, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [1:0] sel, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat);
        @(negedge clk);
        issue(sel, av, bv);
        wait_done(tag, exp_res, exp_lat, (exp_lat == 33) ? 32 : 0, 0, POKE_NONE);
    endtask

    initial begin
        Rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        divsel = OP_DIV;
        a      = 32'd0;
        b      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset res", res, 32'd0);
        Rst = 1'b0;

        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu 100%7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem -7%2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem 7%-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("remu 0%5", OP_REMU, 32'd0, 32'd5, 32'd0, 33);
        run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem 5%0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("rem -8%0", OP_REM, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 1);
        run_op("remu 1234%0", OP_REMU, 32'd1234, 32'd0, 32'd1234, 1);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu min/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Start and flush together in IDLE: the request is dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; divsel = OP_DIV; a = 32'd9; b = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start done", {31'd0, done}, 32'd0);
        check("flush+start busy", {31'd0, busy}, 32'd0);
        check("flush+start res", res, 32'd0);

        // Start during CALC is ignored.
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done("ignore start", 32'd333, 33, 32, 10, POKE_START);

        // Flush during CALC: no done, result held, next request accepted.
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done("flush calc", 32'd333, 0, 10, 10, POKE_FLUSH);
        run_op("after flush", OP_REMU, 32'd1000, 32'd3, 32'd1, 33);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("async rst", 32'd0, 0, 10, 10, POKE_RESET);

        // Back-to-back: second request issued in the DONE cycle of the first.
        run_op("b2b first", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done("b2b second", 32'd333, 33, 32, 0, POKE_NONE);
        issue(OP_DIV, 32'd5, 32'd0);
        wait_done("b2b fast", 32'hFFFF_FFFF, 1, 0, 0, POKE_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
